// File: rtl/i2c_target_if.sv
// I2C pin bundle between a bus master (or its model) and the i2c_target responder.
// SDA_IN is the resolved open-drain level; SDA_OUT/SDA_OE are the target's drive request.
interface i2c_target_if;
    logic SCL;
    logic SDA_IN;
    logic SDA_OUT;
    logic SDA_OE;

    modport master (
        output SCL,
        output SDA_IN,
        input  SDA_OUT,
        input  SDA_OE
    );

    modport slave (
        input  SCL,
        input  SDA_IN,
        output SDA_OUT,
        output SDA_OE
    );
endinterface

// File: rtl/i2c_target.sv
// I2C responder holding one 16-bit register: accepts a two-byte write and serves a
// two-byte read, with SCL/SDA oversampled by CLK so the whole block lives in one domain.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h5A
) (
    input  logic        CLK,
    input  logic        RST,
    i2c_target_if.slave bus,
    input  logic [15:0] RD_DATA,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        BUSY,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_BYTE,
        S_WR_ACK,
        S_RD_BYTE,
        S_RD_ACK,
        S_WAIT_STOP
    } state_t;

    // Pin conditioning: two synchronizer stages plus a previous-value flop for edges.
    logic scl_s1, scl_s2, scl_prev;
    logic sda_s1, sda_s2, sda_prev;

    always_ff @(posedge CLK) begin
        scl_s1   <= bus.SCL;
        scl_s2   <= scl_s1;
        scl_prev <= scl_s2;
        sda_s1   <= bus.SDA_IN;
        sda_s2   <= sda_s1;
        sda_prev <= sda_s2;
    end

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  = scl_s2 & ~scl_prev;
    assign scl_fall  = ~scl_s2 & scl_prev;
    assign start_det = scl_s2 & sda_prev & ~sda_s2;
    assign stop_det  = scl_s2 & ~sda_prev & sda_s2;

    state_t      state_r, state_n;
    logic [2:0]  bit_cnt_r, bit_cnt_n;
    logic        byte_idx_r, byte_idx_n;
    logic        ack_phase_r, ack_phase_n;
    logic        rnw_r, rnw_n;
    logic [7:0]  rx_r, rx_n;
    logic [7:0]  wr_hi_r, wr_hi_n;
    logic [15:0] rd_sr_r, rd_sr_n;
    logic        sda_out_r, sda_out_n;
    logic        sda_oe_r, sda_oe_n;
    logic        busy_r, busy_n;
    logic [15:0] wr_data_r, wr_data_n;
    logic        wr_stb_r, wr_stb_n;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r     <= S_IDLE;
            bit_cnt_r   <= 3'd7;
            byte_idx_r  <= 1'b0;
            ack_phase_r <= 1'b0;
            rnw_r       <= 1'b0;
            rx_r        <= 8'h00;
            wr_hi_r     <= 8'h00;
            rd_sr_r     <= 16'h0000;
            sda_out_r   <= 1'b1;
            sda_oe_r    <= 1'b0;
            busy_r      <= 1'b0;
            wr_data_r   <= 16'h0000;
            wr_stb_r    <= 1'b0;
        end else begin
            state_r     <= state_n;
            bit_cnt_r   <= bit_cnt_n;
            byte_idx_r  <= byte_idx_n;
            ack_phase_r <= ack_phase_n;
            rnw_r       <= rnw_n;
            rx_r        <= rx_n;
            wr_hi_r     <= wr_hi_n;
            rd_sr_r     <= rd_sr_n;
            sda_out_r   <= sda_out_n;
            sda_oe_r    <= sda_oe_n;
            busy_r      <= busy_n;
            wr_data_r   <= wr_data_n;
            wr_stb_r    <= wr_stb_n;
        end
    end

    // ack_phase marks the second half of an ACK slot: 0 = waiting for the fall that
    // starts the slot, 1 = slot in progress, next fall ends it.
    always_comb begin
        state_n     = state_r;
        bit_cnt_n   = bit_cnt_r;
        byte_idx_n  = byte_idx_r;
        ack_phase_n = ack_phase_r;
        rnw_n       = rnw_r;
        rx_n        = rx_r;
        wr_hi_n     = wr_hi_r;
        rd_sr_n     = rd_sr_r;
        sda_out_n   = sda_out_r;
        sda_oe_n    = sda_oe_r;
        busy_n      = busy_r;
        wr_data_n   = wr_data_r;
        wr_stb_n    = 1'b0;

        if (stop_det) begin
            state_n     = S_IDLE;
            ack_phase_n = 1'b0;
            sda_oe_n    = 1'b0;
            sda_out_n   = 1'b1;
            busy_n      = 1'b0;
        end else if (start_det) begin
            state_n     = S_ADDR;
            bit_cnt_n   = 3'd7;
            ack_phase_n = 1'b0;
            sda_oe_n    = 1'b0;
            sda_out_n   = 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    sda_oe_n  = 1'b0;
                    sda_out_n = 1'b1;
                    busy_n    = 1'b0;
                end

                S_ADDR: begin
                    if (scl_rise) begin
                        rx_n      = {rx_r[6:0], sda_s2};
                        bit_cnt_n = bit_cnt_r - 3'd1;
                        if (bit_cnt_r == 3'd0) begin
                            if (rx_r[6:0] == TARGET_ADDR) begin
                                state_n     = S_ADDR_ACK;
                                rnw_n       = sda_s2;
                                ack_phase_n = 1'b0;
                            end else begin
                                state_n = S_IDLE;
                                busy_n  = 1'b0;
                            end
                        end
                    end
                end

                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_r) begin
                            ack_phase_n = 1'b1;
                            sda_oe_n    = 1'b1;
                            sda_out_n   = 1'b0;
                            busy_n      = 1'b1;
                            rd_sr_n     = RD_DATA;
                        end else begin
                            ack_phase_n = 1'b0;
                            bit_cnt_n   = 3'd7;
                            byte_idx_n  = 1'b0;
                            if (rnw_r) begin
                                // First read bit goes out on the same fall that ends the ACK.
                                state_n   = S_RD_BYTE;
                                sda_oe_n  = 1'b1;
                                sda_out_n = rd_sr_r[15];
                                rd_sr_n   = {rd_sr_r[14:0], 1'b0};
                            end else begin
                                state_n   = S_WR_BYTE;
                                sda_oe_n  = 1'b0;
                                sda_out_n = 1'b1;
                            end
                        end
                    end
                end

                S_WR_BYTE: begin
                    if (scl_rise) begin
                        rx_n      = {rx_r[6:0], sda_s2};
                        bit_cnt_n = bit_cnt_r - 3'd1;
                        if (bit_cnt_r == 3'd0) begin
                            if (!byte_idx_r) begin
                                wr_hi_n = {rx_r[6:0], sda_s2};
                            end
                            state_n     = S_WR_ACK;
                            ack_phase_n = 1'b0;
                        end
                    end
                end

                // WR_DATA/WR_STB form a valid-only handshake: WR_STB is a one-CLK valid
                // qualifying WR_DATA; the consumer has no ready and must take it then.
                S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_r) begin
                            ack_phase_n = 1'b1;
                            sda_oe_n    = 1'b1;
                            sda_out_n   = 1'b0;
                        end else begin
                            ack_phase_n = 1'b0;
                            sda_oe_n    = 1'b0;
                            sda_out_n   = 1'b1;
                            if (!byte_idx_r) begin
                                state_n    = S_WR_BYTE;
                                byte_idx_n = 1'b1;
                                bit_cnt_n  = 3'd7;
                            end else begin
                                state_n   = S_WAIT_STOP;
                                wr_data_n = {wr_hi_r, rx_r};
                                wr_stb_n  = 1'b1;
                            end
                        end
                    end
                end

                S_RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_r == 3'd0) begin
                            state_n     = S_RD_ACK;
                            ack_phase_n = 1'b0;
                            sda_oe_n    = 1'b0;
                            sda_out_n   = 1'b1;
                        end else begin
                            bit_cnt_n = bit_cnt_r - 3'd1;
                            sda_oe_n  = 1'b1;
                            sda_out_n = rd_sr_r[15];
                            rd_sr_n   = {rd_sr_r[14:0], 1'b0};
                        end
                    end
                end

                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s2 && !byte_idx_r) begin
                            ack_phase_n = 1'b1;
                        end else begin
                            state_n = S_WAIT_STOP;
                        end
                    end else if (scl_fall && ack_phase_r) begin
                        state_n     = S_RD_BYTE;
                        ack_phase_n = 1'b0;
                        byte_idx_n  = 1'b1;
                        bit_cnt_n   = 3'd7;
                        sda_oe_n    = 1'b1;
                        sda_out_n   = rd_sr_r[15];
                        rd_sr_n     = {rd_sr_r[14:0], 1'b0};
                    end
                end

                S_WAIT_STOP: begin
                    sda_oe_n  = 1'b0;
                    sda_out_n = 1'b1;
                end

                default: begin
                    state_n  = S_IDLE;
                    sda_oe_n = 1'b0;
                    busy_n   = 1'b0;
                end
            endcase
        end
    end

    assign bus.SDA_OUT = sda_out_r;
    assign bus.SDA_OE  = sda_oe_r;
    assign WR_DATA     = wr_data_r;
    assign WR_STB      = wr_stb_r;
    assign BUSY        = busy_r;
    assign state_dbg   = state_r;

endmodule
